// File: rtl/zoom_scheduler.sv
// Zoom scheduler: launches the nearest-neighbour scaling engine on zoom requests
// and swaps the displayed frame buffer on the next vertical blank.
module zoom_scheduler #(
  parameter logic [23:0] TIMEOUT    = 24'd8_000_000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       zoom_in_req,
  input  logic       zoom_out_req,
  input  logic       zoom_rst_req,
  input  logic       vblank,
  input  logic       eng_done,
  output logic       eng_start,
  output logic [1:0] eng_zoom_sel,
  output logic [1:0] level,
  output logic       buf_sel,
  output logic       busy,
  output logic       error
);

  // state     | meaning
  // IDLE      | displayed level is final, waiting for a request
  // LAUNCH    | one-cycle engine start, timeout counter starts at 0
  // RUN       | engine rendering into the back buffer
  // SWAP_WAIT | frame ready, waiting for vblank to flip buffers
  // FAULT     | engine timed out, only zoom_rst_req recovers
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SWAP   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic [2:0]  state, state_n;
  logic [1:0]  target, target_n;
  logic        pend_valid, pend_valid_n;
  logic [1:0]  pend_target, pend_target_n;
  logic [23:0] cnt, cnt_n;
  logic [1:0]  level_n;
  logic        buf_n;
  logic        auto_go;

  logic [1:0]  ref_lvl;
  logic        req_valid;
  logic [1:0]  req_target;
  logic        eff_valid;
  logic [1:0]  eff_target;

  always_comb begin
    ref_lvl    = (state == S_IDLE) ? level : (pend_valid ? pend_target : target);
    req_valid  = 1'b0;
    req_target = 2'd0;
    if (zoom_rst_req) begin
      req_valid  = 1'b1;
      req_target = 2'd0;
    end else if (zoom_in_req && !zoom_out_req) begin
      req_valid  = 1'b1;
      req_target = (ref_lvl >= 2'd2) ? 2'd2 : ref_lvl + 2'd1;
    end else if (zoom_out_req && !zoom_in_req) begin
      req_valid  = 1'b1;
      req_target = (ref_lvl == 2'd0) ? 2'd0 : ref_lvl - 2'd1;
    end
  end

  // A request arriving on the swap edge itself overrides the stored pending one.
  assign eff_valid  = req_valid | pend_valid;
  assign eff_target = req_valid ? req_target : pend_target;

  always_comb begin
    state_n       = state;
    target_n      = target;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    cnt_n         = cnt;
    level_n       = level;
    buf_n         = buf_sel;
    case (state)
      S_IDLE: begin
        if (auto_go) begin
          state_n  = S_LAUNCH;
          target_n = 2'd0;
        end else if (req_valid && req_target != level) begin
          state_n  = S_LAUNCH;
          target_n = req_target;
        end
      end
      S_LAUNCH: begin
        state_n = S_RUN;
        cnt_n   = cnt + 24'd1;
      end
      S_RUN: begin
        if (eng_done) begin
          state_n = S_SWAP;
        end else if (cnt == TIMEOUT - 24'd1) begin
          state_n = S_FAULT;
        end else if (cnt != 24'hFF_FFFF) begin
          cnt_n = cnt + 24'd1;
        end
      end
      S_SWAP: begin
        if (vblank) begin
          buf_n        = ~buf_sel;
          level_n      = target;
          pend_valid_n = 1'b0;
          if (eff_valid && eff_target != target) begin
            state_n  = S_LAUNCH;
            target_n = eff_target;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (zoom_rst_req) begin
          state_n      = S_LAUNCH;
          target_n     = 2'd0;
          pend_valid_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if ((state == S_LAUNCH || state == S_RUN || (state == S_SWAP && !vblank)) && req_valid) begin
      pend_valid_n  = 1'b1;
      pend_target_n = req_target;
    end

    // The counter reads 0 during LAUNCH so it measures cycles since eng_start.
    if (state_n == S_LAUNCH) cnt_n = 24'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      target      <= 2'd0;
      pend_valid  <= 1'b0;
      pend_target <= 2'd0;
      cnt         <= 24'd0;
      level       <= 2'd0;
      buf_sel     <= 1'b0;
      eng_start   <= 1'b0;
      auto_go     <= AUTO_START;
    end else begin
      state       <= state_n;
      target      <= target_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      cnt         <= cnt_n;
      level       <= level_n;
      buf_sel     <= buf_n;
      eng_start   <= (state_n == S_LAUNCH);
      auto_go     <= 1'b0;
    end
  end

  assign eng_zoom_sel = target;
  assign busy         = (state == S_LAUNCH) || (state == S_RUN) || (state == S_SWAP);
  assign error        = (state == S_FAULT);

endmodule

// File: tb/tb_zoom_scheduler.sv
// Bench for zoom_scheduler: a cycle model checked every cycle plus directed
// scenarios with literal expectations; a second instance covers auto-start.
module tb_zoom_scheduler;

  localparam logic [23:0] TO   = 24'd100;
  localparam int          TO_I = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zin = 1'b0, zout = 1'b0, zrst = 1'b0, vblank = 1'b0, done = 1'b0;
  logic       eng_start, buf_sel, busy, error;
  logic [1:0] sel, level;
  logic       a_start, a_buf, a_busy, a_error;
  logic [1:0] a_sel, a_level;

  int tests = 0;
  int fails = 0;
  int start_count = 0;

  always #5 clk = ~clk;

  zoom_scheduler #(.TIMEOUT(TO), .AUTO_START(1'b0)) dut (
    .clk(clk), .rst(rst), .zoom_in_req(zin), .zoom_out_req(zout), .zoom_rst_req(zrst),
    .vblank(vblank), .eng_done(done), .eng_start(eng_start), .eng_zoom_sel(sel),
    .level(level), .buf_sel(buf_sel), .busy(busy), .error(error)
  );

  zoom_scheduler #(.TIMEOUT(TO), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst(rst), .zoom_in_req(1'b0), .zoom_out_req(1'b0), .zoom_rst_req(1'b0),
    .vblank(1'b1), .eng_done(1'b1), .eng_start(a_start), .eng_zoom_sel(a_sel),
    .level(a_level), .buf_sel(a_buf), .busy(a_busy), .error(a_error)
  );

  // Model: launched/job/swap/fault flags, age = cycles since eng_start, pend = -1 when empty.
  int m_level = 0, m_sel = 0, m_age = 0, m_pend = -1;
  bit m_buf = 0, m_start = 0, m_job = 0, m_swap = 0, m_fault = 0;

  function automatic int req_of(int ref_l, logic i, logic o, logic r);
    if (r) return 0;
    if (i && !o) return (ref_l >= 2) ? 2 : ref_l + 1;
    if (o && !i) return (ref_l <= 0) ? 0 : ref_l - 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int lv, sl, ag, pd, rq;
    bit bf, st, jb, sw, ft;
    if (rst) begin
      m_level <= 0; m_sel <= 0; m_age <= 0; m_pend <= -1;
      m_buf <= 0; m_start <= 0; m_job <= 0; m_swap <= 0; m_fault <= 0;
    end else begin
      lv = m_level; sl = m_sel; ag = m_age; pd = m_pend;
      bf = m_buf; st = m_start; jb = m_job; sw = m_swap; ft = m_fault;
      if (ft) begin
        if (zrst) begin ft = 0; st = 1; sl = 0; pd = -1; end
      end else if (st) begin
        st = 0; jb = 1; ag = 1;
        rq = req_of((pd >= 0) ? pd : sl, zin, zout, zrst);
        if (rq >= 0) pd = rq;
      end else if (jb) begin
        rq = req_of((pd >= 0) ? pd : sl, zin, zout, zrst);
        if (rq >= 0) pd = rq;
        if (done) begin jb = 0; sw = 1; end
        else if (ag == TO_I - 1) begin jb = 0; ft = 1; end
        else ag = ag + 1;
      end else if (sw) begin
        rq = req_of((pd >= 0) ? pd : sl, zin, zout, zrst);
        if (rq >= 0) pd = rq;
        if (vblank) begin
          bf = !bf; lv = sl; sw = 0;
          if (pd >= 0 && pd != sl) begin st = 1; sl = pd; end
          pd = -1;
        end
      end else begin
        rq = req_of(lv, zin, zout, zrst);
        if (rq >= 0 && rq != lv) begin st = 1; sl = rq; end
      end
      m_level <= lv; m_sel <= sl; m_age <= ag; m_pend <= pd;
      m_buf <= bf; m_start <= st; m_job <= jb; m_swap <= sw; m_fault <= ft;
    end
  end

  always @(negedge clk) begin
    tests++;
    if (eng_start !== m_start || sel !== 2'(m_sel) || level !== 2'(m_level) ||
        buf_sel !== m_buf || busy !== (m_start | m_job | m_swap) || error !== m_fault) begin
      fails++;
      $display("FAIL model t=%0t: dut start=%b sel=%0d lvl=%0d buf=%b busy=%b err=%b, required start=%b sel=%0d lvl=%0d buf=%b busy=%b err=%b",
               $time, eng_start, sel, level, buf_sel, busy, error,
               m_start, m_sel, m_level, m_buf, m_start | m_job | m_swap, m_fault);
    end
    if (eng_start === 1'b1) start_count++;
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_in();  zin = 1'b1;  tick(1); zin = 1'b0;  endtask
  task automatic pulse_out(); zout = 1'b1; tick(1); zout = 1'b0; endtask
  task automatic pulse_rst(); zrst = 1'b1; tick(1); zrst = 1'b0; endtask

  task automatic wait_start(string name);
    for (int i = 0; i < 8 && eng_start !== 1'b1; i++) tick(1);
    chk(name, int'(eng_start === 1'b1), 1);
  endtask

  // Starts in the eng_start cycle: done after dd cycles, vblank dv cycles after that.
  task automatic run_job(int dd, int dv);
    tick(dd);
    done = 1'b1; tick(1); done = 1'b0;
    if (dv > 1) tick(dv - 1);
    vblank = 1'b1; tick(1); vblank = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int sc0;
    int n;
    tick(3);
    chk("rst_start", eng_start, 0);
    chk("rst_sel", sel, 0);
    chk("rst_level", level, 0);
    chk("rst_buf", buf_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_auto_start", a_start, 0);

    rst = 1'b0;
    tick(1);
    chk("auto_start", a_start, 1);
    chk("auto_sel", a_sel, 0);
    tick(5);
    chk("auto_buf", a_buf, 1);
    chk("auto_level", a_level, 0);
    chk("auto_idle", a_busy, 0);

    pulse_in();
    wait_start("basic_start");
    chk("basic_sel", sel, 1);
    run_job(50, 10);
    chk("basic_level", level, 1);
    chk("basic_buf", buf_sel, 1);
    chk("basic_busy", busy, 0);

    pulse_in();
    wait_start("lvl2_start");
    chk("lvl2_sel", sel, 2);
    run_job(20, 3);
    chk("lvl2_level", level, 2);
    chk("lvl2_buf", buf_sel, 0);
    sc0 = start_count;
    pulse_in();
    tick(4);
    chk("sat_in_nostart", start_count - sc0, 0);
    chk("sat_in_busy", busy, 0);

    pulse_rst();
    wait_start("zrst_start");
    chk("zrst_sel", sel, 0);
    run_job(5, 2);
    chk("zrst_level", level, 0);
    chk("zrst_buf", buf_sel, 1);
    sc0 = start_count;
    pulse_out();
    tick(4);
    chk("sat_out_nostart", start_count - sc0, 0);

    sc0 = start_count;
    zin = 1'b1; zout = 1'b1; tick(1); zin = 1'b0; zout = 1'b0;
    tick(4);
    chk("cancel_nostart", start_count - sc0, 0);
    done = 1'b1; tick(2); done = 1'b0;
    chk("idle_done_busy", busy, 0);

    do_reset();
    pulse_in();
    wait_start("pend_start");
    tick(5);
    pulse_in();
    tick(2);
    pulse_out();
    pulse_in();
    tick(10);
    done = 1'b1; tick(1); done = 1'b0;
    tick(2);
    vblank = 1'b1; tick(1); vblank = 1'b0;
    chk("pend_mid_level", level, 1);
    chk("pend_mid_buf", buf_sel, 1);
    chk("pend_relaunch", eng_start, 1);
    chk("pend_sel", sel, 2);
    run_job(30, 4);
    chk("pend_level", level, 2);
    chk("pend_buf", buf_sel, 0);
    chk("pend_busy", busy, 0);

    do_reset();
    pulse_in();
    wait_start("to_start");
    n = 0;
    while (error !== 1'b1 && n < 150) begin
      tick(1);
      n++;
    end
    chk("timeout_cycles", n, 100);
    chk("timeout_level", level, 0);
    chk("timeout_buf", buf_sel, 0);
    chk("timeout_busy", busy, 0);
    pulse_in();
    tick(3);
    chk("fault_ignores_in", error, 1);
    pulse_rst();
    chk("fault_rst_start", eng_start, 1);
    chk("fault_rst_sel", sel, 0);
    chk("fault_rst_error", error, 0);
    run_job(5, 1);
    chk("fault_rec_level", level, 0);
    chk("fault_rec_buf", buf_sel, 1);

    pulse_in();
    wait_start("tie_start");
    tick(99);
    done = 1'b1; tick(1); done = 1'b0;
    chk("tie_error", error, 0);
    chk("tie_busy", busy, 1);
    vblank = 1'b1; tick(1); vblank = 1'b0;
    chk("tie_level", level, 1);

    pulse_in();
    wait_start("rstrun_start");
    tick(3);
    rst = 1'b1;
    #2;
    chk("rstrun_level", level, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_sel", sel, 0);
    chk("rstrun_start", eng_start, 0);
    tick(1);
    chk("rstrun_start_hold", eng_start, 0);
    rst = 1'b0;
    tick(3);
    chk("rstrun_idle", busy, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zoom_scheduler.md
ZOOM_SCHEDULER -- requirements
Module: zoom_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 24'd8_000_000: the maximum number of RUN cycles to wait for eng_done.
REQ-002 Parameter AUTO_START, default 1: when 1, a 1x frame is launched automatically after reset.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 zoom_in_req  in  1  single-cycle pulse; request one level more zoom.
REQ-006 zoom_out_req  in  1  single-cycle pulse; request one level less zoom.
REQ-007 zoom_rst_req  in  1  single-cycle pulse; request level 0 (1x); also clears a fault.
REQ-008 vblank  in  1  display vertical-blanking flag, synchronous to clk.
REQ-009 eng_done  in  1  done from the nearest-neighbour scaling engine.
REQ-010 eng_start  out  1  single-cycle start pulse to the scaling engine.
REQ-011 eng_zoom_sel  out  2  zoom code to the engine: 00=1x, 01=2x, 10=4x; 11 is never driven.
REQ-012 level  out  2  zoom level currently displayed.
REQ-013 buf_sel  out  1  front (displayed) frame buffer; the engine writes buffer ~buf_sel.
REQ-014 busy  out  1  high in every state except IDLE and FAULT.
REQ-015 error  out  1  high while in FAULT.

Function
REQ-016 States: IDLE, LAUNCH, RUN, SWAP_WAIT, FAULT.
REQ-017 Target computation, in priority order:
- zoom_rst_req -> target 0.
- Else zoom_in_req alone -> target = min(current reference + 1, 2).
- Else zoom_out_req alone -> target = max(current reference - 1, 0).
- zoom_in_req and zoom_out_req in the same cycle cancel; no request is generated.
REQ-018 In IDLE, the current reference is level; a request whose target differs from level -> LAUNCH next cycle; a target equal to level is ignored.
REQ-019 LAUNCH lasts exactly 1 cycle:
- eng_start = 1;
- eng_zoom_sel = target;
- timeout counter cleared;
- -> RUN.
REQ-020 eng_zoom_sel holds stable from LAUNCH until SWAP_WAIT is exited.
REQ-021 RUN:
- the counter increments each cycle;
- eng_done = 1 -> SWAP_WAIT;
- otherwise counter == TIMEOUT-1 -> FAULT;
- if both occur in the same cycle, eng_done wins.
REQ-022 An eng_done asserted during IDLE, LAUNCH, SWAP_WAIT or FAULT is ignored.
REQ-023 SWAP_WAIT: on the first cycle with vblank = 1, buf_sel toggles and level <= target in that same edge; then -> LAUNCH if a pending request exists, else -> IDLE.
REQ-024 Requests arriving in LAUNCH, RUN or SWAP_WAIT go into a single pending slot:
- the current reference is the pending target if one is valid, else target;
- the last request wins;
- a pending target equal to the newly displayed level is discarded at the swap.
REQ-025 When leaving SWAP_WAIT to LAUNCH, target <= pending target and the pending slot is cleared.
REQ-026 FAULT:
- error = 1;
- eng_start = 0;
- buf_sel and level unchanged;
- zoom_in_req and zoom_out_req are ignored;
- zoom_rst_req clears error, sets target 0, clears pending and -> LAUNCH (even if level = 0).
REQ-027 The timeout counter is 24 bits wide and never wraps; it saturates in FAULT.
REQ-028 eng_start is registered, never high on two consecutive cycles, and never high outside LAUNCH.

Reset
REQ-029 On rst:
- state IDLE;
- eng_start = 0, eng_zoom_sel = 00, level = 0, buf_sel = 0, busy = 0, error = 0;
- target = 0, pending slot empty, counter = 0.
REQ-030 With AUTO_START = 1, the first clock after rst deassertion enters LAUNCH with target 0, and the normal sequence (including buffer swap) follows.
REQ-031 rst asserted mid-operation aborts immediately to the reset values; no eng_start is issued while rst is high.

Verification
REQ-032 Basic zoom-in:
- stimulus: AUTO_START = 0, reset, zoom_in_req pulse, eng_done 50 cycles after eng_start, vblank 10 cycles later;
- response: one eng_start with eng_zoom_sel = 01; buf_sel 0 -> 1 and level = 1 on the vblank edge; busy returns low.
REQ-033 Saturation: from level 2, zoom_in_req -> no eng_start and busy stays 0; from level 0, zoom_out_req -> no eng_start.
REQ-034 Pending requests:
- stimulus: from level 0, zoom_in_req; during RUN, zoom_in_req, zoom_out_req, zoom_in_req on separate cycles;
- response: after the first swap (level 1), a second LAUNCH with eng_zoom_sel = 10; final level 2 and buf_sel back to 0.
REQ-035 Timeout: TIMEOUT = 100, eng_done never asserted -> error = 1 exactly 100 cycles after eng_start; level and buf_sel unchanged; zoom_rst_req -> eng_start with eng_zoom_sel = 00 and error = 0.
REQ-036 Edge cases:
- zoom_in_req and zoom_out_req in the same cycle -> no launch;
- eng_done and timeout in the same cycle -> SWAP_WAIT, error stays 0;
- rst pulse during RUN -> all outputs at reset values on the next sampled edge.
